time_set_ctrl: RTL and testbench

- User-input side of the wall clock: turns three raw push-buttons into time-edit commands.
- Holds an editable hour/minute copy and stalls the timekeeping chain while editing.
- On commit, issues a one-cycle load strobe so the hour/minute counters take the edited value.
- Sits beside the hour/minute/second counters; its edit_field output drives field blinking in segment display control.

---
 rtl/clock_pkg.sv | 53 +++++
 rtl/button_debounce.sv | 94 +++++++++
 rtl/time_set_ctrl.sv | 169 ++++++++++++++++
 tb/tb_time_set_ctrl.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/clock_pkg.sv
// ---------------------------------------------------------------------------
// clock_pkg
// Shared definitions for the wall-clock time-setting logic:
//   - state_e      : edit FSM states (RUN / EDIT_HOUR / EDIT_MINUTE / COMMIT)
//   - HOUR_MAX     : largest legal hour value (23)
//   - MINUTE_MAX   : largest legal minute value (59)
//   - EF_*         : edit_field codes consumed by the display blink logic
//   - hour_step    : compare-and-wrap hour increment/decrement
//   - minute_step  : compare-and-wrap minute increment/decrement
// ---------------------------------------------------------------------------
package clock_pkg;

  typedef enum logic [1:0] {
    ST_RUN         = 2'd0,
    ST_EDIT_HOUR   = 2'd1,
    ST_EDIT_MINUTE = 2'd2,
    ST_COMMIT      = 2'd3
  } state_e;

  localparam logic [4:0] HOUR_MAX   = 5'd23;
  localparam logic [5:0] MINUTE_MAX = 6'd59;

  localparam logic [1:0] EF_NONE   = 2'b00;
  localparam logic [1:0] EF_HOUR   = 2'b01;
  localparam logic [1:0] EF_MINUTE = 2'b10;

  // One hour step. Any value at or beyond the top of the range is treated
  // as the wrap point so an out-of-range value can never be produced.
  function automatic logic [4:0] hour_step(input logic [4:0] hour,
                                           input logic       up);
    logic [4:0] res;
    if (up) begin
      res = (hour >= HOUR_MAX) ? 5'd0 : hour + 5'd1;
    end else begin
      res = ((hour == 5'd0) || (hour > HOUR_MAX)) ? HOUR_MAX : hour - 5'd1;
    end
    return res;
  endfunction

  // One minute step, same wrap rules as hour_step.
  function automatic logic [5:0] minute_step(input logic [5:0] minute,
                                             input logic       up);
    logic [5:0] res;
    if (up) begin
      res = (minute >= MINUTE_MAX) ? 6'd0 : minute + 6'd1;
    end else begin
      res = ((minute == 6'd0) || (minute > MINUTE_MAX)) ? MINUTE_MAX
                                                         : minute - 6'd1;
    end
    return res;
  endfunction

endpackage

// File: rtl/button_debounce.sv
// ---------------------------------------------------------------------------
// button_debounce
// Conditions one raw, asynchronous push-button into single-cycle press
// pulses: 2-flop synchronizer, counter-based debounce, rising-edge pulse
// and (when REPEAT_EN=1) auto-repeat while the button stays held.
//
// Ports:
//   clock     in   system clock
//   reset     in   synchronous, active-low reset
//   btn_raw_i in   raw button level, active high, asynchronous
//   press_o   out  registered one-cycle press pulse
// ---------------------------------------------------------------------------
module button_debounce #(
  parameter int unsigned DEBOUNCE_LEN  = 1000,
  parameter int unsigned REPEAT_DELAY  = 50000,
  parameter int unsigned REPEAT_PERIOD = 10000,
  parameter int unsigned CNT_W         = 16,
  parameter bit          REPEAT_EN     = 1'b0
) (
  input  logic clock,
  input  logic reset,
  input  logic btn_raw_i,
  output logic press_o
);

  // Debounce terminal count: the flip happens on the edge where the
  // DEBOUNCE_LEN-th consecutive disagreeing sample is seen.
  localparam logic [CNT_W-1:0] DEB_LAST   = CNT_W'(DEBOUNCE_LEN - 1);
  // Repeat counter equals "cycles since the debounced rise" up to the first
  // repeat; after each repeat it is reloaded so that it reaches REP_AT again
  // exactly REPEAT_PERIOD cycles later (no modulo needed).
  localparam logic [CNT_W-1:0] REP_AT     = CNT_W'(REPEAT_DELAY);
  localparam logic [CNT_W-1:0] REP_RELOAD = CNT_W'(REPEAT_DELAY - REPEAT_PERIOD + 1);

  logic             sync1_q, sync2_q;
  logic             deb_q, deb_d;
  logic             deb_prev_q;
  logic [CNT_W-1:0] deb_cnt_q, deb_cnt_d;
  logic [CNT_W-1:0] rep_cnt_q, rep_cnt_d;
  logic             rep_fire;
  logic             press_q, press_d;

  always_comb begin
    deb_d     = deb_q;
    deb_cnt_d = '0;
    if (sync2_q != deb_q) begin
      if (deb_cnt_q == DEB_LAST) begin
        deb_d = ~deb_q;
      end else begin
        deb_cnt_d = deb_cnt_q + CNT_W'(1);
      end
    end
  end

  always_comb begin
    rep_fire  = 1'b0;
    rep_cnt_d = '0;
    if (REPEAT_EN && deb_q) begin
      if (rep_cnt_q == REP_AT) begin
        rep_fire  = 1'b1;
        rep_cnt_d = REP_RELOAD;
      end else begin
        rep_cnt_d = rep_cnt_q + CNT_W'(1);
      end
    end
  end

  // Fresh debounced rise (seen one cycle late through deb_prev_q) or a
  // repeat tick while still held.
  assign press_d = deb_q & (~deb_prev_q | rep_fire);

  always_ff @(posedge clock) begin
    if (!reset) begin
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      deb_q      <= 1'b0;
      deb_prev_q <= 1'b0;
      deb_cnt_q  <= '0;
      rep_cnt_q  <= '0;
      press_q    <= 1'b0;
    end else begin
      sync1_q    <= btn_raw_i;
      sync2_q    <= sync1_q;
      deb_q      <= deb_d;
      deb_prev_q <= deb_q;
      deb_cnt_q  <= deb_cnt_d;
      rep_cnt_q  <= rep_cnt_d;
      press_q    <= press_d;
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/time_set_ctrl.sv
// ---------------------------------------------------------------------------
// time_set_ctrl
// User-input side of the wall clock. Three push-buttons (mode/up/down) edit
// a private hour/minute copy while the timekeeping chain is stalled; on
// commit a one-cycle load strobe hands the edited time to the counters.
//
// Ports:
//   clock          in   system clock
//   reset          in   synchronous, active-low reset
//   btn_mode       in   raw mode button (async, active high)
//   btn_up         in   raw increment button (async, active high)
//   btn_down       in   raw decrement button (async, active high)
//   cur_hour       in   live hour (0-23), captured when editing starts
//   cur_minute     in   live minute (0-59), captured when editing starts
//   set_hour       out  edited hour, registered
//   set_minute     out  edited minute, registered
//   load           out  one-cycle strobe: counters take set_hour/set_minute
//   clock_run_flag out  1 = time advances, 0 while editing/committing
//   edit_field     out  00 none, 01 hour, 10 minute (drives display blink)
// ---------------------------------------------------------------------------
module time_set_ctrl
  import clock_pkg::*;
#(
  parameter int unsigned DEBOUNCE_LEN  = 1000,
  parameter int unsigned REPEAT_DELAY  = 50000,
  parameter int unsigned REPEAT_PERIOD = 10000,
  parameter int unsigned CNT_W         = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       btn_mode,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic [4:0] cur_hour,
  input  logic [5:0] cur_minute,
  output logic [4:0] set_hour,
  output logic [5:0] set_minute,
  output logic       load,
  output logic       clock_run_flag,
  output logic [1:0] edit_field
);

  logic press_mode, press_up, press_down;

  button_debounce #(
    .DEBOUNCE_LEN (DEBOUNCE_LEN),
    .REPEAT_DELAY (REPEAT_DELAY),
    .REPEAT_PERIOD(REPEAT_PERIOD),
    .CNT_W        (CNT_W),
    .REPEAT_EN    (1'b0)
  ) u_btn_mode (
    .clock    (clock),
    .reset    (reset),
    .btn_raw_i(btn_mode),
    .press_o  (press_mode)
  );

  button_debounce #(
    .DEBOUNCE_LEN (DEBOUNCE_LEN),
    .REPEAT_DELAY (REPEAT_DELAY),
    .REPEAT_PERIOD(REPEAT_PERIOD),
    .CNT_W        (CNT_W),
    .REPEAT_EN    (1'b1)
  ) u_btn_up (
    .clock    (clock),
    .reset    (reset),
    .btn_raw_i(btn_up),
    .press_o  (press_up)
  );

  button_debounce #(
    .DEBOUNCE_LEN (DEBOUNCE_LEN),
    .REPEAT_DELAY (REPEAT_DELAY),
    .REPEAT_PERIOD(REPEAT_PERIOD),
    .CNT_W        (CNT_W),
    .REPEAT_EN    (1'b1)
  ) u_btn_down (
    .clock    (clock),
    .reset    (reset),
    .btn_raw_i(btn_down),
    .press_o  (press_down)
  );

  state_e     state_q, state_d;
  logic [4:0] set_hour_q, set_hour_d;
  logic [5:0] set_minute_q, set_minute_d;
  logic       load_q, load_d;
  logic       run_q, run_d;
  logic [1:0] field_q, field_d;

  // Up and down in the same cycle cancel out.
  logic step_up, step_down;
  assign step_up   = press_up & ~press_down;
  assign step_down = press_down & ~press_up;

  always_comb begin
    state_d      = state_q;
    set_hour_d   = set_hour_q;
    set_minute_d = set_minute_q;

    case (state_q)
      ST_RUN: begin
        // Live time is captured only here; later changes are ignored.
        if (press_mode) begin
          state_d      = ST_EDIT_HOUR;
          set_hour_d   = cur_hour;
          set_minute_d = cur_minute;
        end
      end
      ST_EDIT_HOUR: begin
        // Mode has priority; a coincident up/down is dropped.
        if (press_mode) begin
          state_d = ST_EDIT_MINUTE;
        end else if (step_up || step_down) begin
          set_hour_d = hour_step(set_hour_q, step_up);
        end
      end
      ST_EDIT_MINUTE: begin
        if (press_mode) begin
          state_d = ST_COMMIT;
        end else if (step_up || step_down) begin
          set_minute_d = minute_step(set_minute_q, step_up);
        end
      end
      ST_COMMIT: begin
        state_d = ST_RUN;
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase

    // Outputs are registered versions of the decode of the next state, so
    // they line up with state_q without a combinational output path.
    load_d  = (state_d == ST_COMMIT);
    run_d   = (state_d == ST_RUN);
    field_d = EF_NONE;
    case (state_d)
      ST_EDIT_HOUR:   field_d = EF_HOUR;
      ST_EDIT_MINUTE: field_d = EF_MINUTE;
      default:        field_d = EF_NONE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q      <= ST_RUN;
      set_hour_q   <= 5'd0;
      set_minute_q <= 6'd0;
      load_q       <= 1'b0;
      run_q        <= 1'b1;
      field_q      <= EF_NONE;
    end else begin
      state_q      <= state_d;
      set_hour_q   <= set_hour_d;
      set_minute_q <= set_minute_d;
      load_q       <= load_d;
      run_q        <= run_d;
      field_q      <= field_d;
    end
  end

  assign set_hour       = set_hour_q;
  assign set_minute     = set_minute_q;
  assign load           = load_q;
  assign clock_run_flag = run_q;
  assign edit_field     = field_q;

endmodule

// File: tb/tb_time_set_ctrl.sv
module tb_time_set_ctrl;

  localparam int DL   = 4;
  localparam int RD   = 20;
  localparam int RP   = 5;
  localparam int MAXE = 12000;

  logic       clock = 1'b0;
  logic       reset;
  logic       btn_mode, btn_up, btn_down;
  logic [4:0] cur_hour;
  logic [5:0] cur_minute;
  logic [4:0] set_hour;
  logic [5:0] set_minute;
  logic       load, clock_run_flag;
  logic [1:0] edit_field;

  time_set_ctrl #(
    .DEBOUNCE_LEN (DL),
    .REPEAT_DELAY (RD),
    .REPEAT_PERIOD(RP),
    .CNT_W        (16)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .btn_mode      (btn_mode),
    .btn_up        (btn_up),
    .btn_down      (btn_down),
    .cur_hour      (cur_hour),
    .cur_minute    (cur_minute),
    .set_hour      (set_hour),
    .set_minute    (set_minute),
    .load          (load),
    .clock_run_flag(clock_run_flag),
    .edit_field    (edit_field)
  );

  initial forever #5 clock = ~clock;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int cyc; int h; int m; int ld; int run; int fld;
  } ev_t;
  ev_t exp_q[$];

  bit s1_h  [3][MAXE];
  bit s2_h  [3][MAXE];
  bit deb_h [3][MAXE];
  bit pul_h [3][MAXE];
  int rise_e[3];

  int m_edge  = 0;
  int m_state = 0;   // 0 running, 1 hour edit, 2 minute edit, 3 commit
  int m_h = 0, m_m = 0;
  int p_h = 0, p_m = 0, p_ld = 0, p_run = 1, p_fld = 0;

  task automatic model_step(input bit rstn, input bit rm, input bit ru, input bit rdn,
                            input int ch, input int cm);
    bit raw [3];
    int e, k, ld, run, fld;
    bit pm, pu, pd, dprev, flip;
    ev_t ev;
    raw[0] = rm; raw[1] = ru; raw[2] = rdn;
    m_edge++;
    e = m_edge;
    if (e >= MAXE) begin
      $display("FAIL model_range: edge %0d, limit %0d", e, MAXE);
      $fatal(1, "model history exhausted");
    end
    if (!rstn) begin
      m_state = 0; m_h = 0; m_m = 0;
      for (int b = 0; b < 3; b++) begin
        s1_h[b][e] = 0; s2_h[b][e] = 0; deb_h[b][e] = 0; pul_h[b][e] = 0;
        rise_e[b] = -1;
      end
    end else begin
      pm = pul_h[0][e-1]; pu = pul_h[1][e-1]; pd = pul_h[2][e-1];
      case (m_state)
        0: if (pm) begin m_state = 1; m_h = ch; m_m = cm; end
        1: begin
          if (pm) m_state = 2;
          else if (pu && !pd) m_h = (m_h + 1) % 24;
          else if (pd && !pu) m_h = (m_h + 23) % 24;
        end
        2: begin
          if (pm) m_state = 3;
          else if (pu && !pd) m_m = (m_m + 1) % 60;
          else if (pd && !pu) m_m = (m_m + 59) % 60;
        end
        default: m_state = 0;
      endcase
      for (int b = 0; b < 3; b++) begin
        dprev = deb_h[b][e-1];
        k = e - 1 - rise_e[b];
        pul_h[b][e] = dprev && (k == 0 || (b != 0 && k >= RD && ((k - RD) % RP) == 0));
        s1_h[b][e] = raw[b];
        s2_h[b][e] = s1_h[b][e-1];
        // Level is accepted once the last DL synchronized samples all disagree.
        flip = 1;
        for (int j = 1; j <= DL; j++)
          if (e - j < 1 || s2_h[b][e-j] == dprev) flip = 0;
        deb_h[b][e] = flip ? !dprev : dprev;
        if (deb_h[b][e] && !dprev) rise_e[b] = e;
      end
    end
    ld  = (m_state == 3);
    run = (m_state == 0);
    fld = (m_state == 1) ? 1 : (m_state == 2) ? 2 : 0;
    if (ld != 0 || m_h != p_h || m_m != p_m || run != p_run || fld != p_fld || ld != p_ld) begin
      ev.cyc = e; ev.h = m_h; ev.m = m_m; ev.ld = ld; ev.run = run; ev.fld = fld;
      exp_q.push_back(ev);
    end
    p_h = m_h; p_m = m_m; p_ld = ld; p_run = run; p_fld = fld;
  endtask

  // ---------------- monitor ----------------
  int edge_n = 0;
  always @(posedge clock) edge_n++;

  logic [4:0] q_h   = 5'd0;
  logic [5:0] q_m   = 6'd0;
  logic       q_ld  = 1'b0;
  logic       q_run = 1'b1;
  logic [1:0] q_fld = 2'd0;
  int load_seen = 0;

  always @(negedge clock) begin
    ev_t ev;
    if (load === 1'b1) load_seen++;
    if (load !== 1'b0 || set_hour !== q_h || set_minute !== q_m ||
        clock_run_flag !== q_run || edit_field !== q_fld || load !== q_ld) begin
      chk_cnt++;
      if (exp_q.size() == 0) begin
        $display("FAIL sb_unexpected @edge %0d: got h=%0d m=%0d load=%0d run=%0d field=%0d, expected no change",
                 edge_n, set_hour, set_minute, load, clock_run_flag, edit_field);
      end else begin
        ev = exp_q.pop_front();
        if (ev.cyc == edge_n && set_hour === 5'(ev.h) && set_minute === 6'(ev.m) &&
            load === 1'(ev.ld) && clock_run_flag === 1'(ev.run) && edit_field === 2'(ev.fld))
          pass_cnt++;
        else
          $display("FAIL sb_event: got edge=%0d h=%0d m=%0d load=%0d run=%0d field=%0d, expected edge=%0d h=%0d m=%0d load=%0d run=%0d field=%0d",
                   edge_n, set_hour, set_minute, load, clock_run_flag, edit_field,
                   ev.cyc, ev.h, ev.m, ev.ld, ev.run, ev.fld);
      end
    end
    q_h = set_hour; q_m = set_minute; q_ld = load; q_run = clock_run_flag; q_fld = edit_field;
  end

  // ---------------- stimulus ----------------
  bit r_rstn = 0, r_mode = 0, r_up = 0, r_down = 0;
  int r_ch = 0, r_cm = 0;

  task automatic tick();
    reset = r_rstn; btn_mode = r_mode; btn_up = r_up; btn_down = r_down;
    cur_hour = 5'(r_ch); cur_minute = 6'(r_cm);
    model_step(r_rstn, r_mode, r_up, r_down, r_ch, r_cm);
    @(posedge clock);
    #2;
  endtask

  task automatic idle(input int n);
    r_mode = 0; r_up = 0; r_down = 0;
    repeat (n) tick();
  endtask

  task automatic press(input bit m, input bit u, input bit d, input int hold, input int gap);
    r_mode = m; r_up = u; r_down = d;
    repeat (hold) tick();
    idle(gap);
  endtask

  initial begin
    int ls, len;
    // 1: reset held with buttons toggling
    r_rstn = 0;
    for (int i = 0; i < 3; i++) begin
      r_mode = i[0]; r_up = ~i[0]; r_down = 1; tick();
    end
    chk("rst_load", load, 0);
    chk("rst_run", clock_run_flag, 1);
    chk("rst_field", edit_field, 0);
    chk("rst_hour", set_hour, 0);
    chk("rst_minute", set_minute, 0);
    r_rstn = 1;
    idle(12);
    chk("post_rst_run", clock_run_flag, 1);

    // 3 (entry): capture 13:45
    r_ch = 13; r_cm = 45;
    press(1, 0, 0, 8, 10);
    r_ch = 7; r_cm = 7;
    chk("edit_hour_h", set_hour, 13);
    chk("edit_hour_m", set_minute, 45);
    chk("edit_hour_run", clock_run_flag, 0);
    chk("edit_hour_field", edit_field, 1);
    // 2: glitch then clean hold
    press(0, 1, 0, 2, 10);
    chk("glitch_ignored", set_hour, 13);
    press(0, 1, 0, 10, 12);
    chk("held_plus1", set_hour, 14);
    // 3: wrap 23 -> 0, then down wraps back to 23
    for (int i = 0; i < 10; i++) press(0, 1, 0, 8, 10);
    chk("hour_wrap_up", set_hour, 0);
    press(0, 0, 1, 8, 10);
    chk("hour_wrap_down", set_hour, 23);
    // 4: minute wrap, simultaneous up/down, commit
    press(1, 0, 0, 8, 10);
    chk("edit_min_field", edit_field, 2);
    for (int i = 0; i < 14; i++) press(0, 1, 0, 8, 10);
    chk("minute_59", set_minute, 59);
    press(0, 1, 0, 8, 10);
    chk("minute_wrap", set_minute, 0);
    press(0, 1, 1, 8, 10);
    chk("updown_cancel", set_minute, 0);
    ls = load_seen;
    press(1, 0, 0, 8, 10);
    chk("commit_one_load", load_seen - ls, 1);
    chk("commit_run", clock_run_flag, 1);
    chk("commit_field", edit_field, 0);
    chk("commit_hour", set_hour, 23);
    // 5: auto-repeat from 5
    r_ch = 5; r_cm = 30;
    press(1, 0, 0, 8, 10);
    chk("rep_start", set_hour, 5);
    press(0, 1, 0, 2 + DL + 1 + RD + 15, 20);
    chk("rep_model", set_hour, 5'(m_h));
    idle(30);
    chk("rep_release", set_hour, 5'(m_h));
    // 6: reset mid minute-edit
    press(1, 0, 0, 8, 10);
    chk("pre_rst_field", edit_field, 2);
    ls = load_seen;
    r_rstn = 0; tick(); r_rstn = 1;
    idle(10);
    chk("midrst_noload", load_seen - ls, 0);
    chk("midrst_run", clock_run_flag, 1);
    chk("midrst_hour", set_hour, 0);
    chk("midrst_minute", set_minute, 0);

    // randomized phase
    for (int s = 0; s < 220; s++) begin
      r_ch = $urandom_range(0, 23);
      r_cm = $urandom_range(0, 59);
      if ($urandom_range(0, 59) == 0) begin
        r_rstn = 0; r_mode = $urandom_range(0, 1);
        len = $urandom_range(1, 2);
      end else begin
        r_rstn = 1;
        r_mode = ($urandom_range(0, 4) == 0);
        r_up   = ($urandom_range(0, 2) == 0);
        r_down = ($urandom_range(0, 2) == 0);
        len = $urandom_range(1, 45);
      end
      repeat (len) tick();
    end
    r_rstn = 1;
    idle(100);
    chk("final_hour", set_hour, 5'(m_h));
    chk("final_minute", set_minute, 6'(m_m));
    chk("sb_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
